// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  // Latency counter width; 4 bits covers LATENCY up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Expand a byte-lane mask into a 32-bit bit-enable.
  function automatic logic [31:0] mask_to_ben(input logic [3:0] mask);
    logic [31:0] ben;
    ben = '0;
    for (int b = 0; b < 4; b++) ben[8*b +: 8] = {8{mask[b]}};
    return ben;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word storage with per-byte write enable and combinational read.
// No reset: contents survive rst_n.
module dmem_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // One independent byte-wide array per lane keeps each lane's writes local.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];

    // Byte-lane write on the rising edge when this lane is enabled.
    always_ff @(posedge clk) begin
      if (we[b]) mem[addr] <= wdata[8*b +: 8];
    end

    assign rdata[8*b +: 8] = mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: accepts one request at a time,
// completes it LATENCY cycles later with a one-cycle valid pulse.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_busy,
  output logic        o_dmem_valid,
  output logic        o_dmem_err
);

  localparam int               AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0]      DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] addr_q, wdata_q;
  logic [3:0]  mask_q;
  logic        ren_q, wen_q;

  logic        accept;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_mask;
  logic        cur_ren, cur_wen, cur_err;
  logic        enter_resp, do_write;
  logic [3:0]  sram_we;
  logic [31:0] sram_rdata;

  assign accept      = (state_q == IDLE) && (i_dmem_ren || i_dmem_wen);
  assign o_dmem_busy = (state_q != IDLE);

  // With LATENCY==1 the response edge is also the accept edge, so the
  // request fields come straight from the inputs while idle.
  assign cur_addr  = (state_q == IDLE) ? i_dmem_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? i_dmem_wdata : wdata_q;
  assign cur_mask  = (state_q == IDLE) ? i_dmem_mask  : mask_q;
  assign cur_ren   = (state_q == IDLE) ? i_dmem_ren   : ren_q;
  assign cur_wen   = (state_q == IDLE) ? i_dmem_wen   : wen_q;

  // Illegal: both strobes, misaligned, or beyond the storage.
  assign cur_err = (cur_ren && cur_wen) || (cur_addr[1:0] != 2'b00) ||
                   ({2'b00, cur_addr[31:2]} >= DEPTH_L);

  // Storage is touched only on the edge entering RESP, and never under reset.
  assign enter_resp = (state_d == RESP);
  assign do_write   = rst_n && enter_resp && cur_wen && !cur_err;
  assign sram_we    = {4{do_write}} & cur_mask;

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (clk),
    .addr  (cur_addr[AW+1:2]),
    .we    (sram_we),
    .wdata (cur_wdata),
    .rdata (sram_rdata)
  );

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request fields at the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= i_dmem_addr;
      wdata_q <= i_dmem_wdata;
      mask_q  <= i_dmem_mask;
      ren_q   <= i_dmem_ren;
      wen_q   <= i_dmem_wen;
    end
  end

  // Response registers: valid/err for the RESP cycle; rdata only moves on
  // a read or error response and otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_dmem_valid <= 1'b0;
      o_dmem_err   <= 1'b0;
      o_dmem_rdata <= '0;
    end else begin
      o_dmem_valid <= enter_resp;
      o_dmem_err   <= enter_resp && cur_err;
      if (enter_resp) begin
        if (cur_err)      o_dmem_rdata <= '0;
        else if (cur_ren) o_dmem_rdata <= sram_rdata & mask_to_ben(cur_mask);
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized checks against a deadline-based transaction model.
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic        ren, wen;
  logic [3:0]  mask;
  logic [31:0] rdata;
  logic        busy, valid, err;

  logic        ren_s;
  logic [31:0] rd1, rd15;
  logic        b1, b15, v1, v15, e1, e15;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_dmem_addr(addr), .i_dmem_ren(ren),
    .i_dmem_wen(wen), .i_dmem_wdata(wdata), .i_dmem_mask(mask),
    .o_dmem_rdata(rdata), .o_dmem_busy(busy), .o_dmem_valid(valid),
    .o_dmem_err(err));

  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .i_dmem_addr(32'h0), .i_dmem_ren(ren_s),
    .i_dmem_wen(1'b0), .i_dmem_wdata(32'h0), .i_dmem_mask(4'hF),
    .o_dmem_rdata(rd1), .o_dmem_busy(b1), .o_dmem_valid(v1),
    .o_dmem_err(e1));

  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(15)) u_l15 (
    .clk(clk), .rst_n(rst_n), .i_dmem_addr(32'h0), .i_dmem_ren(ren_s),
    .i_dmem_wen(1'b0), .i_dmem_wdata(32'h0), .i_dmem_mask(4'hF),
    .o_dmem_rdata(rd15), .o_dmem_busy(b15), .o_dmem_valid(v15),
    .o_dmem_err(e15));

  int n_vec = 0;
  int n_bad = 0;
  int cycle = 0;

  // Reference model: a request occupies the port from its accept cycle
  // through its response cycle; effects land in the response cycle.
  logic [31:0] mem [DEPTH];
  bit          m_busy = 0, m_pend = 0;
  int          m_due;
  logic        m_r, m_w;
  logic [31:0] m_a, m_d;
  logic [3:0]  m_m;
  logic        exp_valid = 0, exp_err = 0;
  logic [31:0] exp_rdata = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, want, cycle);
    end
  endtask

  function automatic logic [31:0] ben_of(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m);
    bit acc, bad;
    int idx;
    if (!rst_n) begin
      m_busy = 0; m_pend = 0;
      exp_valid = 0; exp_err = 0; exp_rdata = 0;
      return;
    end
    exp_valid = 0; exp_err = 0;
    acc = !m_busy && (r || w);
    if (m_busy && !m_pend) m_busy = 0;
    if (acc) begin
      m_busy = 1; m_pend = 1; m_due = cycle + LAT;
      m_r = r; m_w = w; m_a = a; m_d = d; m_m = m;
    end
    if (m_pend && m_due == cycle + 1) begin
      m_pend = 0;
      exp_valid = 1;
      bad = (m_r && m_w) || (m_a[1:0] != 0) || (m_a / 4 >= DEPTH);
      idx = int'(m_a / 4) % DEPTH;
      if (bad) begin
        exp_err = 1; exp_rdata = 0;
      end else if (m_w) begin
        mem[idx] = (mem[idx] & ~ben_of(m_m)) | (m_d & ben_of(m_m));
      end else begin
        exp_rdata = mem[idx] & ben_of(m_m);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    ren = r; wen = w; addr = a; wdata = d; mask = m;
    @(posedge clk); #1;
    model_step(r, w, a, d, m);
    cycle++;
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("err",   32'(err),   32'(exp_err));
    chk("busy",  32'(busy),  32'(m_busy));
    chk("rdata", rdata,      exp_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  logic [31:0] saved;
  int          pulses, last1, last15, np1, np15;

  initial begin
    ren_s = 0;
    rst_n = 0;
    idle(3);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1;

    // Write accepted in the very first cycle out of reset; valid two cycles on.
    cyc(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    idle(1);
    chk("wr_valid", 32'(valid), 32'h1);
    chk("wr_err", 32'(err), 32'h0);
    idle(1);
    cyc(1, 0, 32'h10, 32'h0, 4'hF);
    idle(1);
    chk("rd_deadbeef", rdata, 32'hDEADBEEF);
    chk("rd_valid", 32'(valid), 32'h1);
    idle(1);

    // Byte store into the top lane, then full and half-word reads.
    cyc(0, 1, 32'h10, 32'hAB000000, 4'h8); idle(2);
    cyc(1, 0, 32'h10, 32'h0, 4'hF); idle(1);
    chk("sb_full", rdata, 32'hABADBEEF); idle(1);
    cyc(1, 0, 32'h10, 32'h0, 4'h3); idle(1);
    chk("sb_half", rdata, 32'h0000BEEF); idle(1);
    cyc(1, 0, 32'h10, 32'h0, 4'h0); idle(1);
    chk("mask0_read", rdata, 32'h0); idle(1);

    // Seed a working set of words.
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 32'(i * 4), $urandom, 4'hF);
      idle(2);
    end

    // Illegal requests.
    saved = mem[8];
    cyc(1, 1, 32'h20, 32'h12345678, 4'hF); idle(1);
    chk("both_err", 32'(err), 32'h1); idle(1);
    cyc(0, 1, 32'h22, 32'h12345678, 4'hF); idle(1);
    chk("misalign_err", 32'(err), 32'h1); idle(1);
    cyc(1, 0, 32'h1000, 32'h0, 4'hF); idle(1);
    chk("range_err", 32'(err), 32'h1);
    chk("range_rdata", rdata, 32'h0); idle(1);
    cyc(1, 0, 32'h20, 32'h0, 4'hF); idle(1);
    chk("err_nowrite", rdata, saved); idle(1);

    // Request held continuously: one accept per LAT+1 cycles.
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 32'h14, 32'h0, 4'hF);
      if (valid) pulses++;
    end
    chk("held_pulses", 32'(pulses), 32'd2);
    idle(2);

    // Reset while the write waits: the write must never land.
    saved = mem[6];
    cyc(0, 1, 32'h18, ~saved, 4'hF);
    rst_n = 0;
    idle(1);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    idle(1);
    rst_n = 1;
    cyc(1, 0, 32'h18, 32'h0, 4'hF); idle(1);
    chk("rst_olddata", rdata, saved); idle(1);

    // Randomized traffic with occasional illegal requests and resets.
    for (int i = 0; i < 400; i++) begin
      logic r, w;
      logic [31:0] a;
      int k;
      rst_n = ($urandom_range(63) != 0);
      k = $urandom_range(15);
      a = 32'($urandom_range(31) * 4);
      if (k == 0) a = a | 32'($urandom_range(1, 3));
      if (k == 1) a = 32'h1000 + 32'($urandom_range(255) * 4);
      r = $urandom_range(1); w = !r;
      if (k == 2) begin r = 1; w = 1; end
      if ($urandom_range(2) == 0) begin r = 0; w = 0; end
      cyc(r, w, a, $urandom, 4'($urandom_range(15)));
    end
    rst_n = 1;
    idle(3);

    // Back-to-back reads on the LATENCY=1 and LATENCY=15 instances.
    last1 = -1; last15 = -1; np1 = 0; np15 = 0;
    ren_s = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (v1) begin
        if (last1 >= 0) chk("lat1_gap", 32'(i - last1), 32'd2);
        last1 = i; np1++;
      end
      if (v15) begin
        if (last15 >= 0) chk("lat15_gap", 32'(i - last15), 32'd16);
        last15 = i; np15++;
      end
    end
    ren_s = 0;
    chk("lat1_pulses", 32'(np1), 32'd20);
    chk("lat15_pulses", 32'(np15), 32'd2);
    chk("lat1_first", 32'(np1 > 0 ? last1 - 2 * (np1 - 1) : -1), 32'd0);
    chk("lat15_first", 32'(np15 > 0 ? last15 - 16 * (np15 - 1) : -1), 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
